// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter
//  Purpose  : Round-robin arbiter over NUM_ENTRIES requesters. It returns a
//             one-hot grant in the same cycle as the request. The priority
//             pointer rotates past the winner only when the consumer accepts
//             the grant. A sticky self-check flags any illegal grant encoding.
//  Ports    : clk          - clock, rising edge
//             reset        - synchronous, active-high reset
//             request      - bit i set = requester i wants service
//             update_lru   - consumer accepted the current grant
//             grant_oh     - one-hot grant, zero when there is no request
//             grant_idx    - binary index of the grant, zero when idle
//             grant_valid  - OR-reduction of grant_oh
//             check_error  - sticky illegal-grant flag, cleared by reset
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0] grant_idx,
    output logic                   grant_valid,
    output logic                   check_error
);

    // The scan index is one bit wider than the pointer so that ptr + k
    // cannot overflow before it is wrapped.
    localparam int                     c_scan_w    = INDEX_WIDTH + 1;
    localparam logic [c_scan_w-1:0]    c_last_scan = c_scan_w'(NUM_ENTRIES - 1);
    localparam logic [c_scan_w-1:0]    c_num_scan  = c_scan_w'(NUM_ENTRIES);
    localparam logic [INDEX_WIDTH-1:0] c_last_idx  = INDEX_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [INDEX_WIDTH-1:0] c_one_idx   = INDEX_WIDTH'(1);
    localparam logic [NUM_ENTRIES-1:0] c_one_vec   = NUM_ENTRIES'(1);

    // Elaboration-time parameter sanity checks.
    if (NUM_ENTRIES < 2) begin : g_bad_num_entries
        $error("rr_grant_arbiter: NUM_ENTRIES must be at least 2");
    end
    if (INDEX_WIDTH != $clog2(NUM_ENTRIES)) begin : g_bad_index_width
        $error("rr_grant_arbiter: INDEX_WIDTH must equal clog2(NUM_ENTRIES)");
    end

    logic [INDEX_WIDTH-1:0] r_ptr;
    logic                   r_check_error;

    logic [NUM_ENTRIES-1:0] w_grant_oh;
    logic [INDEX_WIDTH-1:0] w_grant_idx;
    logic                   w_found;
    logic [c_scan_w-1:0]    w_scan;
    logic [INDEX_WIDTH-1:0] w_cand;
    logic                   w_grant_valid;
    logic                   w_multi_hot;
    logic                   w_stray;
    logic                   w_missing;
    logic                   w_illegal;

    // Scan upward from r_ptr and wrap at NUM_ENTRIES-1. The wrap is an
    // explicit compare and subtract, so a non-power-of-two NUM_ENTRIES
    // wraps correctly. The first set request bit met in that order wins.
    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan      = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            w_scan = {1'b0, r_ptr} + c_scan_w'(k);
            if (w_scan > c_last_scan) begin
                w_scan = w_scan - c_num_scan;
            end
            w_cand = w_scan[INDEX_WIDTH-1:0];
            if (!w_found && request[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        if (w_found) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    assign w_grant_valid = |w_grant_oh;

    // Self-check terms.
    // A value and (value - 1) share a set bit only when two or more bits are set.
    assign w_multi_hot = |(w_grant_oh & (w_grant_oh - c_one_vec));
    assign w_stray     = |(w_grant_oh & ~request);
    assign w_missing   = (|request) && !w_grant_valid;
    assign w_illegal   = w_multi_hot || w_stray || w_missing;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_check_error <= 1'b0;
        end else begin
            // The winner drops to lowest priority and its successor becomes
            // highest. An accept with no valid grant leaves the pointer as is.
            if (update_lru && w_grant_valid) begin
                r_ptr <= (w_grant_idx == c_last_idx) ? '0 : (w_grant_idx + c_one_idx);
            end
            if (w_illegal) begin
                r_check_error <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only: stop at once on an illegal grant and name the instance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!w_illegal)
            else $fatal(1, "%m: illegal grant encoding grant_oh=%b request=%b",
                        w_grant_oh, request);
        end
    end
`endif

    assign grant_oh    = w_grant_oh;
    assign grant_idx   = w_grant_idx;
    assign grant_valid = w_grant_valid;
    assign check_error = r_check_error;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_arbiter
//  Purpose  : Self-checking bench for rr_grant_arbiter. It drives a 4-entry
//             instance and a 3-entry instance side by side. A queue-based
//             priority-order model in the bench supplies every expected value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic       update_lru;

    logic [3:0] grant_oh4;
    logic [1:0] grant_idx4;
    logic       grant_valid4;
    logic       check_error4;

    logic [2:0] grant_oh3;
    logic [1:0] grant_idx3;
    logic       grant_valid3;
    logic       check_error3;

    int n_checks = 0;
    int n_fail   = 0;

    // Priority order kept by the model: element 0 has the highest priority.
    int order4[$];
    int order3[$];

    rr_grant_arbiter #(.NUM_ENTRIES(4), .INDEX_WIDTH(2)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .update_lru  (update_lru),
        .grant_oh    (grant_oh4),
        .grant_idx   (grant_idx4),
        .grant_valid (grant_valid4),
        .check_error (check_error4)
    );

    rr_grant_arbiter #(.NUM_ENTRIES(3), .INDEX_WIDTH(2)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .request     (request[2:0]),
        .update_lru  (update_lru),
        .grant_oh    (grant_oh3),
        .grant_idx   (grant_idx3),
        .grant_valid (grant_valid3),
        .check_error (check_error3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset order: 0,1,...,n-1.
    task automatic model_reset();
        order4.delete();
        order3.delete();
        for (int i = 0; i < 4; i++) order4.push_back(i);
        for (int i = 0; i < 3; i++) order3.push_back(i);
    endtask

    // Winner = the first entry in priority order whose request bit is set.
    function automatic int winner4(input logic [3:0] req);
        foreach (order4[i]) if (req[order4[i]]) return order4[i];
        return -1;
    endfunction

    function automatic int winner3(input logic [3:0] req);
        foreach (order3[i]) if (req[order3[i]]) return order3[i];
        return -1;
    endfunction

    // On accept, rotate the order until the winner sits at the back.
    task automatic accept4(input int w);
        int t;
        while (order4[order4.size()-1] != w) begin
            t = order4.pop_front();
            order4.push_back(t);
        end
    endtask

    task automatic accept3(input int w);
        int t;
        while (order3[order3.size()-1] != w) begin
            t = order3.pop_front();
            order3.push_back(t);
        end
    endtask

    // One clock cycle: drive the inputs, check all outputs at the falling
    // edge, then let the rising edge update the model.
    task automatic step(input string tag, input logic rst_v, input logic [3:0] req,
                        input logic upd);
        int w4;
        int w3;
        reset      = rst_v;
        request    = req;
        update_lru = upd;
        @(negedge clk);
        w4 = winner4(req);
        w3 = winner3(req);
        chk({tag, "/oh4"},  32'(grant_oh4),    (w4 < 0) ? 32'd0 : (32'd1 << w4));
        chk({tag, "/idx4"}, 32'(grant_idx4),   (w4 < 0) ? 32'd0 : 32'(w4));
        chk({tag, "/vld4"}, 32'(grant_valid4), (w4 < 0) ? 32'd0 : 32'd1);
        chk({tag, "/err4"}, 32'(check_error4), 32'd0);
        chk({tag, "/oh3"},  32'(grant_oh3),    (w3 < 0) ? 32'd0 : (32'd1 << w3));
        chk({tag, "/idx3"}, 32'(grant_idx3),   (w3 < 0) ? 32'd0 : 32'(w3));
        chk({tag, "/vld3"}, 32'(grant_valid3), (w3 < 0) ? 32'd0 : 32'd1);
        chk({tag, "/err3"}, 32'(check_error3), 32'd0);
        @(posedge clk);
        if (rst_v) begin
            model_reset();
        end else if (upd) begin
            if (w4 >= 0) accept4(w4);
            if (w3 >= 0) accept3(w3);
        end
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        request    = 4'b0000;
        update_lru = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state: index 0 has top priority while reset is still held.
        step("rst", 1'b1, 4'b1111, 1'b0);
        chk("rst_oh_const", 32'(grant_oh4), 32'h1);

        // Fairness rotation: the grant follows 0001, 0010, 0100, 1000, 0001.
        for (int i = 0; i < 5; i++) step("fair", 1'b0, 4'b1111, 1'b1);

        // Hold without accept, then a single accept advances the pointer.
        step("rst", 1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'b1111, 1'b0);
        step("hold_acc", 1'b0, 4'b1111, 1'b1);
        step("hold_next", 1'b0, 4'b1111, 1'b0);
        chk("hold_next_const", 32'(grant_oh4), 32'h2);

        // Sparse request 1010: 0010, 1000, 0010.
        step("rst", 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) step("sparse", 1'b0, 4'b1010, 1'b1);

        // Wrap boundary: accept index 2 (ptr becomes 3), then request 1001.
        step("rst", 1'b1, 4'b0000, 1'b0);
        step("wrap_set", 1'b0, 4'b0100, 1'b1);
        step("wrap", 1'b0, 4'b1001, 1'b1);
        step("wrap_after", 1'b0, 4'b1001, 1'b0);

        // Idle accept is ignored and leaves the pointer unchanged.
        step("idle", 1'b0, 4'b0000, 1'b1);
        step("idle_after", 1'b0, 4'b1111, 1'b0);

        // Reset mid-rotation (ptr = 2) drops the rotation history.
        step("mid_set", 1'b0, 4'b0010, 1'b1);
        step("mid_rst", 1'b1, 4'b1111, 1'b1);
        step("mid_after", 1'b0, 4'b1111, 1'b0);

        // Every request value at every pointer position.
        for (int p = 0; p < 4; p++) begin
            step("exh_rst", 1'b1, 4'b0000, 1'b0);
            if (p > 0) step("exh_set", 1'b0, 4'(1 << (p - 1)), 1'b1);
            for (int r = 0; r < 16; r++) step("exh", 1'b0, 4'(r), 1'b0);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
